store_station_scheduler: RTL and testbench

Scheduler for a bank of store reservation stations. It steers each issued store to one free station, arbitrates round-robin among stations that have finished address calculation, and queues their results in a small FIFO. The FIFO drains into the single write-buffer port. The block sits between the issue stage and the write buffer; stations keep their own operand and common-data-bus logic.

---
 rtl/store_station_scheduler_if.sv | 41 ++++
 rtl/store_station_scheduler.sv | 130 +++++++++++++
 tb/tb_store_station_scheduler.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_station_scheduler_if.sv
// Bus bundle between the store scheduler, the issue stage, the reservation stations and the
// write buffer. The master side is the scheduler itself.
interface store_station_scheduler_if #(
  parameter int unsigned STATION_COUNT           = 4,
  parameter int unsigned REORDER_BUFFER_SIZE_LOG = 4,
  parameter int unsigned RESULT_FIFO_DEPTH       = 4
);
  localparam int unsigned CntW = $clog2(RESULT_FIFO_DEPTH) + 1;

  logic                                              flush;
  logic                                              issue_valid;
  logic [REORDER_BUFFER_SIZE_LOG-1:0]                issue_position;
  logic                                              issue_ready;
  logic [STATION_COUNT-1:0]                          station_select;
  logic [STATION_COUNT-1:0]                          station_busy;
  logic [STATION_COUNT-1:0]                          done_valid;
  logic [STATION_COUNT*REORDER_BUFFER_SIZE_LOG-1:0]  done_position;
  logic [STATION_COUNT*32-1:0]                       done_value;
  logic [STATION_COUNT*32-1:0]                       done_storeValue;
  logic [STATION_COUNT-1:0]                          done_ack;
  logic                                              writeBuffer_valid;
  logic                                              writeBuffer_ready;
  logic [REORDER_BUFFER_SIZE_LOG-1:0]                writeBuffer_position;
  logic [31:0]                                       writeBuffer_value;
  logic [31:0]                                       writeBuffer_storeValue;
  logic [CntW-1:0]                                   occupancy;

  modport master (
    input  flush, issue_valid, issue_position, station_busy, done_valid, done_position,
           done_value, done_storeValue, writeBuffer_ready,
    output issue_ready, station_select, done_ack, writeBuffer_valid, writeBuffer_position,
           writeBuffer_value, writeBuffer_storeValue, occupancy
  );

  modport slave (
    output flush, issue_valid, issue_position, station_busy, done_valid, done_position,
           done_value, done_storeValue, writeBuffer_ready,
    input  issue_ready, station_select, done_ack, writeBuffer_valid, writeBuffer_position,
           writeBuffer_value, writeBuffer_storeValue, occupancy
  );
endinterface

// File: rtl/store_station_scheduler.sv
// Steers issued stores to free reservation stations, round-robin arbitrates finished stations
// into a small result FIFO and drains that FIFO into the single write-buffer port.
module store_station_scheduler #(
  parameter int unsigned STATION_COUNT           = 4,
  parameter int unsigned REORDER_BUFFER_SIZE_LOG = 4,
  parameter int unsigned RESULT_FIFO_DEPTH       = 4
) (
  input logic                       clk,
  input logic                       reset,
  store_station_scheduler_if.master bus
);
  localparam int unsigned StW  = $clog2(STATION_COUNT);
  localparam int unsigned PtrW = $clog2(RESULT_FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TagW = REORDER_BUFFER_SIZE_LOG;

  logic [STATION_COUNT-1:0] reserved_q, reserved_d, free, issue_grant, done_grant;
  logic [StW-1:0]           issue_ptr_q, issue_ptr_d, done_ptr_q, done_ptr_d;
  logic [StW-1:0]           issue_idx, done_idx;
  logic                     issue_found, done_found;
  logic [PtrW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]          count_q, count_d;
  logic [TagW-1:0]          pos_mem  [RESULT_FIFO_DEPTH];
  logic [31:0]              val_mem  [RESULT_FIFO_DEPTH];
  logic [31:0]              sval_mem [RESULT_FIFO_DEPTH];
  logic [TagW-1:0]          push_pos;
  logic [31:0]              push_val, push_sval;
  logic                     issue_ok, accept, full, pop, push_ok, push, wb_valid;
  logic                     unused_issue_position;

  // Returns {found, index} of the first request at or above ptr, wrapping.
  function automatic logic [StW:0] rr_pick(input logic [STATION_COUNT-1:0] req,
                                           input logic [StW-1:0] ptr);
    logic [StW:0] res;
    int           idx;
    res = '0;
    for (int k = STATION_COUNT - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % int'(STATION_COUNT);
      if (req[idx]) res = {1'b1, StW'(idx)};
    end
    return res;
  endfunction

  assign unused_issue_position = ^bus.issue_position;

  always_comb begin
    free                       = ~bus.station_busy & ~reserved_q;
    issue_ok                   = (|free) & ~bus.flush & ~reset;
    {issue_found, issue_idx}   = rr_pick(free, issue_ptr_q);
    issue_grant                = issue_found ? (STATION_COUNT'(1) << issue_idx) : '0;
    accept                     = bus.issue_valid & issue_ok;

    wb_valid                   = (count_q != '0);
    pop                        = wb_valid & bus.writeBuffer_ready;
    full                       = (count_q == CntW'(RESULT_FIFO_DEPTH));
    push_ok                    = (~full | pop) & ~bus.flush & ~reset;
    {done_found, done_idx}     = rr_pick(bus.done_valid, done_ptr_q);
    done_grant                 = done_found ? (STATION_COUNT'(1) << done_idx) : '0;
    push                       = push_ok & done_found;

    push_pos  = '0;
    push_val  = '0;
    push_sval = '0;
    for (int i = 0; i < STATION_COUNT; i++) begin
      if (done_grant[i]) begin
        push_pos  = bus.done_position[i*TagW +: TagW];
        push_val  = bus.done_value[i*32 +: 32];
        push_sval = bus.done_storeValue[i*32 +: 32];
      end
    end
  end

  assign bus.issue_ready            = issue_ok;
  assign bus.station_select         = accept ? issue_grant : '0;
  assign bus.done_ack               = push ? done_grant : '0;
  assign bus.writeBuffer_valid      = wb_valid;
  assign bus.writeBuffer_position   = wb_valid ? pos_mem[head_q] : '0;
  assign bus.writeBuffer_value      = wb_valid ? val_mem[head_q] : '0;
  assign bus.writeBuffer_storeValue = wb_valid ? sval_mem[head_q] : '0;
  assign bus.occupancy              = count_q;

  always_comb begin
    // A reservation bridges the cycle between selection and the station raising busy.
    reserved_d  = (reserved_q & ~bus.station_busy) | bus.station_select;
    issue_ptr_d = issue_ptr_q;
    done_ptr_d  = done_ptr_q;
    if (accept) begin
      issue_ptr_d = (issue_idx == StW'(STATION_COUNT - 1)) ? '0 : issue_idx + StW'(1);
    end
    if (push) begin
      done_ptr_d = (done_idx == StW'(STATION_COUNT - 1)) ? '0 : done_idx + StW'(1);
    end
    head_d  = head_q + PtrW'(pop);
    tail_d  = tail_q + PtrW'(push);
    count_d = count_q + CntW'(push) - CntW'(pop);
    if (bus.flush) begin
      reserved_d = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reserved_q  <= '0;
      issue_ptr_q <= '0;
      done_ptr_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      reserved_q  <= reserved_d;
      issue_ptr_q <= issue_ptr_d;
      done_ptr_q  <= done_ptr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: head fields are masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pos_mem[tail_q]  <= push_pos;
      val_mem[tail_q]  <= push_val;
      sval_mem[tail_q] <= push_sval;
    end
  end
endmodule

// File: tb/tb_store_station_scheduler.sv
// Directed bench for store_station_scheduler: issue steering, completion arbitration,
// FIFO full/stall behaviour, flush and asynchronous reset.
module tb_store_station_scheduler;
  localparam int unsigned SC = 4;
  localparam int unsigned TW = 4;
  localparam int unsigned FD = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  store_station_scheduler_if #(
    .STATION_COUNT(SC), .REORDER_BUFFER_SIZE_LOG(TW), .RESULT_FIFO_DEPTH(FD)
  ) bus ();

  store_station_scheduler #(
    .STATION_COUNT(SC), .REORDER_BUFFER_SIZE_LOG(TW), .RESULT_FIFO_DEPTH(FD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic set_station(input int i, input logic [TW-1:0] pos, input logic [31:0] val,
                             input logic [31:0] sval);
    bus.done_position[i*TW +: TW] = pos;
    bus.done_value[i*32 +: 32]    = val;
    bus.done_storeValue[i*32 +: 32] = sval;
  endtask

  task automatic test_reset();
    bus.issue_valid = 1'b1;
    bus.done_valid  = 4'b1111;
    @(negedge clk); #1;
    checks++; if (bus.issue_ready !== 1'b0) begin errors++;
      $display("FAIL rst_issue_ready: got %b exp 0", bus.issue_ready); end
    checks++; if (bus.station_select !== 4'b0000) begin errors++;
      $display("FAIL rst_select: got %b exp 0000", bus.station_select); end
    checks++; if (bus.done_ack !== 4'b0000) begin errors++;
      $display("FAIL rst_ack: got %b exp 0000", bus.done_ack); end
    checks++; if (bus.writeBuffer_valid !== 1'b0 || bus.occupancy !== 3'd0) begin errors++;
      $display("FAIL rst_fifo: got v=%b occ=%0d exp v=0 occ=0",
               bus.writeBuffer_valid, bus.occupancy); end
    checks++; if (bus.writeBuffer_position !== 4'd0 || bus.writeBuffer_value !== 32'd0 ||
                  bus.writeBuffer_storeValue !== 32'd0) begin errors++;
      $display("FAIL rst_head: got %h/%h/%h exp zeros", bus.writeBuffer_position,
               bus.writeBuffer_value, bus.writeBuffer_storeValue); end
    bus.issue_valid = 1'b0;
    bus.done_valid  = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_issue_rr();
    logic [3:0] exp_sel [4];
    exp_sel[0] = 4'b0001; exp_sel[1] = 4'b0010; exp_sel[2] = 4'b0100; exp_sel[3] = 4'b1000;
    bus.station_busy = 4'b0000;
    bus.issue_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      checks++; if (bus.station_select !== exp_sel[k]) begin errors++;
        $display("FAIL issue_rr%0d: got %b exp %b", k, bus.station_select, exp_sel[k]); end
    end
    @(negedge clk); #1;
    checks++; if (bus.issue_ready !== 1'b0 || bus.station_select !== 4'b0000) begin errors++;
      $display("FAIL issue_all_reserved: got rdy=%b sel=%b exp rdy=0 sel=0000",
               bus.issue_ready, bus.station_select); end
    bus.issue_valid  = 1'b0;
    bus.station_busy = 4'b1111;
    @(negedge clk);
    bus.station_busy = 4'b0000;
    #1;
    checks++; if (bus.issue_ready !== 1'b1) begin errors++;
      $display("FAIL issue_reserved_cleared: got %b exp 1", bus.issue_ready); end
  endtask

  task automatic test_busy();
    @(negedge clk);
    bus.station_busy = 4'b1111;
    bus.issue_valid  = 1'b1;
    #1;
    checks++; if (bus.issue_ready !== 1'b0 || bus.station_select !== 4'b0000) begin errors++;
      $display("FAIL busy_all: got rdy=%b sel=%b exp rdy=0 sel=0000",
               bus.issue_ready, bus.station_select); end
    @(negedge clk);
    bus.station_busy = 4'b1011;
    #1;
    checks++; if (bus.station_select !== 4'b0100) begin errors++;
      $display("FAIL busy_drop2: got %b exp 0100", bus.station_select); end
    @(negedge clk);
    bus.issue_valid  = 1'b0;
    bus.station_busy = 4'b1111;
    @(negedge clk);
    bus.station_busy = 4'b0000;
  endtask

  task automatic test_done_pair();
    bus.writeBuffer_ready = 1'b1;
    set_station(1, 4'd5, 32'h100, 32'hAA);
    set_station(3, 4'd9, 32'h200, 32'hBB);
    bus.done_valid = 4'b1010;
    #1;
    checks++; if (bus.done_ack !== 4'b0010 || bus.writeBuffer_valid !== 1'b0) begin errors++;
      $display("FAIL pair_ack1: got ack=%b v=%b exp ack=0010 v=0",
               bus.done_ack, bus.writeBuffer_valid); end
    @(negedge clk);
    bus.done_valid = 4'b1000;
    #1;
    checks++; if (bus.done_ack !== 4'b1000) begin errors++;
      $display("FAIL pair_ack3: got %b exp 1000", bus.done_ack); end
    checks++; if (bus.writeBuffer_valid !== 1'b1 || bus.writeBuffer_position !== 4'd5 ||
                  bus.writeBuffer_value !== 32'h100 || bus.writeBuffer_storeValue !== 32'hAA)
    begin errors++;
      $display("FAIL pair_head1: got v=%b %0d %h %h exp 1 5 100 aa", bus.writeBuffer_valid,
               bus.writeBuffer_position, bus.writeBuffer_value, bus.writeBuffer_storeValue); end
    @(negedge clk);
    bus.done_valid = 4'b0000;
    #1;
    checks++; if (bus.writeBuffer_position !== 4'd9 || bus.writeBuffer_value !== 32'h200 ||
                  bus.writeBuffer_storeValue !== 32'hBB || bus.occupancy !== 3'd1)
    begin errors++;
      $display("FAIL pair_head2: got %0d %h %h occ=%0d exp 9 200 bb occ=1",
               bus.writeBuffer_position, bus.writeBuffer_value, bus.writeBuffer_storeValue,
               bus.occupancy); end
    @(negedge clk); #1;
    checks++; if (bus.writeBuffer_valid !== 1'b0 || bus.writeBuffer_value !== 32'd0) begin
      errors++;
      $display("FAIL pair_drained: got v=%b val=%h exp v=0 val=0",
               bus.writeBuffer_valid, bus.writeBuffer_value); end
  endtask

  task automatic test_full();
    logic [3:0] exp_pos [3];
    exp_pos[0] = 4'd3; exp_pos[1] = 4'd4; exp_pos[2] = 4'd12;
    bus.writeBuffer_ready = 1'b0;
    for (int i = 0; i < 4; i++) set_station(i, 4'(i + 1), 32'h1000 + i, 32'hD0 + i);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      bus.done_valid = 4'b1111 << i;
      #1;
      checks++; if (bus.done_ack !== (4'b0001 << i) || bus.occupancy !== 3'(i)) begin errors++;
        $display("FAIL full_fill%0d: got ack=%b occ=%0d exp ack=%b occ=%0d", i,
                 bus.done_ack, bus.occupancy, 4'b0001 << i, i); end
    end
    @(negedge clk);
    set_station(0, 4'd12, 32'h2000, 32'hEE);
    bus.done_valid = 4'b0001;
    #1;
    checks++; if (bus.occupancy !== 3'd4 || bus.done_ack !== 4'b0000) begin errors++;
      $display("FAIL full_stall: got occ=%0d ack=%b exp occ=4 ack=0000",
               bus.occupancy, bus.done_ack); end
    @(negedge clk); #1;
    checks++; if (bus.done_ack !== 4'b0000) begin errors++;
      $display("FAIL full_hold: got %b exp 0000", bus.done_ack); end
    @(negedge clk);
    bus.writeBuffer_ready = 1'b1;
    #1;
    checks++; if (bus.done_ack !== 4'b0001 || bus.writeBuffer_position !== 4'd1) begin errors++;
      $display("FAIL full_push_pop: got ack=%b pos=%0d exp ack=0001 pos=1",
               bus.done_ack, bus.writeBuffer_position); end
    @(negedge clk);
    bus.done_valid = 4'b0000;
    #1;
    checks++; if (bus.occupancy !== 3'd4 || bus.writeBuffer_position !== 4'd2) begin errors++;
      $display("FAIL full_same_count: got occ=%0d pos=%0d exp occ=4 pos=2",
               bus.occupancy, bus.writeBuffer_position); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); #1;
      checks++; if (bus.writeBuffer_position !== exp_pos[j] || bus.occupancy !== 3'(3 - j))
      begin errors++;
        $display("FAIL full_drain%0d: got pos=%0d occ=%0d exp pos=%0d occ=%0d", j,
                 bus.writeBuffer_position, bus.occupancy, exp_pos[j], 3 - j); end
    end
    checks++; if (bus.writeBuffer_value !== 32'h2000) begin errors++;
      $display("FAIL full_fifth_value: got %h exp 2000", bus.writeBuffer_value); end
    @(negedge clk); #1;
    checks++; if (bus.writeBuffer_valid !== 1'b0) begin errors++;
      $display("FAIL full_empty: got %b exp 0", bus.writeBuffer_valid); end
  endtask

  task automatic test_flush();
    logic [3:0] dv [3];
    logic [3:0] ack [3];
    dv[0] = 4'b0111; dv[1] = 4'b0101; dv[2] = 4'b0001;
    ack[0] = 4'b0010; ack[1] = 4'b0100; ack[2] = 4'b0001;
    bus.writeBuffer_ready = 1'b0;
    for (int i = 0; i < 4; i++) set_station(i, 4'(i + 4), 32'h300 + i, 32'h40 + i);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.done_valid = dv[k];
      #1;
      checks++; if (bus.done_ack !== ack[k]) begin errors++;
        $display("FAIL flush_queue%0d: got %b exp %b", k, bus.done_ack, ack[k]); end
    end
    @(negedge clk);
    bus.done_valid   = 4'b0000;
    bus.station_busy = 4'b1110;
    bus.issue_valid  = 1'b1;
    #1;
    checks++; if (bus.station_select !== 4'b0001 || bus.occupancy !== 3'd3) begin errors++;
      $display("FAIL flush_reserve: got sel=%b occ=%0d exp sel=0001 occ=3",
               bus.station_select, bus.occupancy); end
    @(negedge clk); #1;
    checks++; if (bus.issue_ready !== 1'b0) begin errors++;
      $display("FAIL flush_reserved_held: got %b exp 0", bus.issue_ready); end
    @(negedge clk);
    bus.flush      = 1'b1;
    bus.done_valid = 4'b0001;
    bus.station_busy = 4'b0000;
    #1;
    checks++; if (bus.done_ack !== 4'b0000 || bus.station_select !== 4'b0000 ||
                  bus.issue_ready !== 1'b0) begin errors++;
      $display("FAIL flush_block: got ack=%b sel=%b rdy=%b exp 0000 0000 0",
               bus.done_ack, bus.station_select, bus.issue_ready); end
    @(negedge clk);
    bus.flush        = 1'b0;
    bus.done_valid   = 4'b0000;
    bus.station_busy = 4'b1110;
    #1;
    checks++; if (bus.occupancy !== 3'd0 || bus.writeBuffer_valid !== 1'b0 ||
                  bus.station_select !== 4'b0001) begin errors++;
      $display("FAIL flush_after: got occ=%0d v=%b sel=%b exp occ=0 v=0 sel=0001",
               bus.occupancy, bus.writeBuffer_valid, bus.station_select); end
    @(negedge clk);
    bus.issue_valid  = 1'b0;
    bus.station_busy = 4'b1111;
    @(negedge clk);
    bus.station_busy = 4'b0000;
  endtask

  task automatic test_async_reset();
    bus.writeBuffer_ready = 1'b0;
    bus.done_valid = 4'b0011;
    #1;
    checks++; if (bus.done_ack !== 4'b0010) begin errors++;
      $display("FAIL areset_q0: got %b exp 0010", bus.done_ack); end
    @(negedge clk);
    bus.done_valid = 4'b0001;
    #1;
    checks++; if (bus.done_ack !== 4'b0001) begin errors++;
      $display("FAIL areset_q1: got %b exp 0001", bus.done_ack); end
    @(negedge clk);
    bus.done_valid = 4'b0100;
    #1;
    checks++; if (bus.occupancy !== 3'd2 || bus.done_ack !== 4'b0100) begin errors++;
      $display("FAIL areset_pre: got occ=%0d ack=%b exp occ=2 ack=0100",
               bus.occupancy, bus.done_ack); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.writeBuffer_valid !== 1'b0 || bus.occupancy !== 3'd0 ||
                  bus.done_ack !== 4'b0000 || bus.writeBuffer_position !== 4'd0) begin errors++;
      $display("FAIL areset_now: got v=%b occ=%0d ack=%b pos=%0d exp 0 0 0000 0",
               bus.writeBuffer_valid, bus.occupancy, bus.done_ack, bus.writeBuffer_position);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.done_ack !== 4'b0100 || bus.writeBuffer_valid !== 1'b0) begin errors++;
      $display("FAIL areset_represent: got ack=%b v=%b exp ack=0100 v=0",
               bus.done_ack, bus.writeBuffer_valid); end
    @(negedge clk);
    bus.done_valid = 4'b0000;
  endtask

  initial begin
    reset                 = 1'b1;
    bus.flush             = 1'b0;
    bus.issue_valid       = 1'b0;
    bus.issue_position    = '0;
    bus.station_busy      = '0;
    bus.done_valid        = '0;
    bus.done_position     = '0;
    bus.done_value        = '0;
    bus.done_storeValue   = '0;
    bus.writeBuffer_ready = 1'b0;
    test_reset();
    test_issue_rr();
    test_busy();
    @(negedge clk);
    test_done_pair();
    test_full();
    test_flush();
    @(negedge clk);
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
